fft_magnitude_stream: RTL and testbench
=======================================

# fft_magnitude_stream

Streaming magnitude stage between the FFT core and the spectrum display RAM writer. It accepts complex FFT bins framed by start-of-packet and end-of-packet flags. It computes an alpha-max-plus-beta-min magnitude approximation in a 3-stage pipeline and emits only the lower half-spectrum (bins 0..FFT_LEN/2-1) as an address/magnitude/valid write stream. It runs entirely in the sys_clk domain.

## Interface
- IN_W, 16: signed width of real and imaginary inputs.
- OUT_W, 24: unsigned magnitude output width.
- FFT_LEN, 1024: points per frame, power of two.
- ADDR_W, 9: output bin address width, equal to log2(FFT_LEN)-1.
- MAG_GAIN_SHIFT, 4: left shift applied to the magnitude before saturation.

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_reset  in  1  synchronous, active-high reset.
- i_fft_real  in  IN_W  signed real part.
- i_fft_imag  in  IN_W  signed imaginary part.
- i_fft_valid  in  1  sample qualifier.
- i_fft_sop  in  1  first bin of a frame; qualified by i_fft_valid.
- i_fft_eop  in  1  last bin of a frame; qualified by i_fft_valid.
- o_fft_addr  out  ADDR_W  bin index.
- o_fft_mag  out  OUT_W  scaled magnitude.
- o_fft_valid  out  1  write strobe for addr/mag.
- o_frame_done  out  1  one-cycle pulse when a well-formed frame completes.
- o_frame_err  out  1  one-cycle pulse on a framing error.

## Operation
- A sample is accepted when i_fft_valid=1. There is no backpressure.
- Bin counter bin_cnt has log2(FFT_LEN) bits.
- The FSM has three states, listed below.
- IDLE: non-sop samples are ignored. On an accepted sop, bin 0 is taken and the FSM goes to EMIT with bin_cnt=1.
- EMIT: accepted samples are emitted with bin_cnt incrementing. After bin FFT_LEN/2-1 is accepted, the FSM goes to DISCARD.
- DISCARD: samples are counted but not emitted. An eop at bin_cnt=FFT_LEN-1 means the frame is good: o_frame_done is scheduled and the FSM goes to IDLE.
- Error: sop while in EMIT or DISCARD.
  - o_frame_err is pulsed.
  - That sample is treated as bin 0 of a new frame: it is emitted, bin_cnt=1, and the FSM stays in or returns to EMIT.
- Error: eop at any bin other than FFT_LEN-1 (including during EMIT).
  - o_frame_err is pulsed and the FSM goes to IDLE.
  - Bins already emitted are not retracted.
- Error: bin FFT_LEN-1 is accepted without eop.
  - o_frame_err is pulsed and the FSM goes to IDLE.
- If sop and eop arrive on the same sample, it is a sop-error or a new-frame start, followed by an eop error. Result: one o_frame_err pulse, the sample is emitted as bin 0, and the FSM goes to IDLE.
- Arithmetic:
  - ar=|real| and ai=|imag|, each IN_W-bit unsigned. |−2^(IN_W−1)| = 2^(IN_W−1) exactly.
  - mx=max(ar,ai), mn=min(ar,ai).
  - m = mx + (mn>>2) + (mn>>3), computed at IN_W+1 bits.
  - o_fft_mag = min(m << MAG_GAIN_SHIFT, 2^OUT_W−1).
- Reset clears the FSM to IDLE, bin_cnt to 0, and all pipeline valid bits. All outputs are 0 after reset.
- A reset mid-frame discards the frame. No done or err pulse is produced.

## Timing
- Latency is 3 cycles from accepted input to o_fft_valid.
  - S1: abs values and bin index are registered.
  - S2: max/min are registered.
  - S3: the sum, shift and saturation are registered to the outputs.
- o_fft_addr and o_fft_mag hold their last value while o_fft_valid=0.
- o_frame_done asserts 3 cycles after the accepted eop, aligned with the pipeline.
- o_frame_err asserts 3 cycles after the offending sample, through a delay line.
- Back-to-back frames with no gap are supported: an eop sample and the next sop on the following cycle.
- Throughput is one bin per cycle.

## Structure
- Shared package fft_vis_pkg holds:
  - the FSM state enum (IDLE, EMIT, DISCARD);
  - default widths IN_W, OUT_W, ADDR_W;
  - FFT_LEN.
- The package is also used by the display side for ADDR_W and OUT_W.
- One natural sub-module is mag_approx_pipe, the 3-stage alpha-max-beta-min datapath with valid and side-band passthrough. The FSM and counter live in the top level.

## Test plan
- Reset, then one frame of 1024 samples with real=3000, imag=4000 on every bin -> 512 writes, addresses 0..511, each mag=82000; then one o_frame_done pulse 3 cycles after eop; o_frame_err=0.
- Frame with bin 0 real=−32768, imag=0 and bin 1 real=0, imag=−5 -> mag[0]=524288, mag[1]=80.
- With MAG_GAIN_SHIFT=9, real=imag=−32768 -> o_fft_mag=16777215 (saturated).
- Second sop at bin 300 -> one o_frame_err pulse; the next write is addr 0 with that sample's value; the frame then completes normally with o_frame_done.
- eop at bin 700 -> o_frame_err pulse and no o_frame_done; samples before the next sop produce no writes.
- Reset asserted at bin 100, then released -> outputs 0 and no valid pulses; a following clean frame produces 512 writes and o_frame_done.

Source files
------------

// File: rtl/fft_vis_pkg.sv
// Shared FFT visualisation definitions: default widths, frame length and the
// framing FSM state encoding used by the magnitude stage and display side.
package fft_vis_pkg;
  localparam int IN_W           = 16;
  localparam int OUT_W          = 24;
  localparam int FFT_LEN        = 1024;
  localparam int ADDR_W         = $clog2(FFT_LEN) - 1;
  localparam int MAG_GAIN_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DISCARD
  } fsm_state_e;
endpackage

// File: rtl/mag_approx_pipe.sv
// Three-stage alpha-max-plus-beta-min magnitude datapath (alpha=1, beta=3/8)
// with valid, bin address and a frame-done tag carried alongside.
module mag_approx_pipe #(
  parameter int IN_W           = 16,
  parameter int OUT_W          = 24,
  parameter int ADDR_W         = 9,
  parameter int MAG_GAIN_SHIFT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vld_i,
  input  logic              tag_i,
  input  logic [IN_W-1:0]   re_i,
  input  logic [IN_W-1:0]   im_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              vld_o,
  output logic              tag_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [OUT_W-1:0]  mag_o
);
  localparam int STAGES = 3;
  localparam int SUM_W  = IN_W + 1;
  localparam int SH_W   = SUM_W + MAG_GAIN_SHIFT;
  localparam int WW     = (SH_W > OUT_W) ? SH_W : OUT_W;

  logic [STAGES:1]   vld_pipe, tag_pipe;
  logic [IN_W-1:0]   ar_d, ai_d, ar_q, ai_q, mx_q, mn_q;
  logic [ADDR_W-1:0] addr1_q, addr2_q, addr3_q;
  logic [SUM_W-1:0]  sum;
  logic [WW-1:0]     sh;
  logic [OUT_W-1:0]  mag_d, mag_q;

  // Two's-complement negate of the most negative value wraps to 2^(IN_W-1),
  // which is exactly right once the result is read as unsigned.
  always_comb begin
    ar_d  = re_i[IN_W-1] ? (~re_i + IN_W'(1)) : re_i;
    ai_d  = im_i[IN_W-1] ? (~im_i + IN_W'(1)) : im_i;
    sum   = SUM_W'(mx_q) + SUM_W'(mn_q >> 2) + SUM_W'(mn_q >> 3);
    sh    = WW'(sum) << MAG_GAIN_SHIFT;
    mag_d = (sh > WW'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : sh[OUT_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      ar_q     <= '0;
      ai_q     <= '0;
      mx_q     <= '0;
      mn_q     <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      addr3_q  <= '0;
      mag_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], vld_i};
      tag_pipe <= {tag_pipe[STAGES-1:1], tag_i};
      if (vld_i) begin
        ar_q    <= ar_d;
        ai_q    <= ai_d;
        addr1_q <= addr_i;
      end
      if (vld_pipe[1]) begin
        mx_q    <= (ar_q >= ai_q) ? ar_q : ai_q;
        mn_q    <= (ar_q >= ai_q) ? ai_q : ar_q;
        addr2_q <= addr1_q;
      end
      // Output registers only move on a real write so addr/mag hold between strobes.
      if (vld_pipe[2]) begin
        mag_q   <= mag_d;
        addr3_q <= addr2_q;
      end
    end
  end

  assign vld_o  = vld_pipe[STAGES];
  assign tag_o  = tag_pipe[STAGES];
  assign addr_o = addr3_q;
  assign mag_o  = mag_q;
endmodule

// File: rtl/fft_magnitude_stream.sv
// Frames the FFT bin stream, forwards the lower half-spectrum through the
// magnitude pipeline and flags completed or malformed frames.
module fft_magnitude_stream #(
  parameter int IN_W           = fft_vis_pkg::IN_W,
  parameter int OUT_W          = fft_vis_pkg::OUT_W,
  parameter int FFT_LEN        = fft_vis_pkg::FFT_LEN,
  parameter int ADDR_W         = fft_vis_pkg::ADDR_W,
  parameter int MAG_GAIN_SHIFT = fft_vis_pkg::MAG_GAIN_SHIFT
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic [IN_W-1:0]   i_fft_real,
  input  logic [IN_W-1:0]   i_fft_imag,
  input  logic              i_fft_valid,
  input  logic              i_fft_sop,
  input  logic              i_fft_eop,
  output logic [ADDR_W-1:0] o_fft_addr,
  output logic [OUT_W-1:0]  o_fft_mag,
  output logic              o_fft_valid,
  output logic              o_frame_done,
  output logic              o_frame_err
);
  localparam int               CNT_W     = $clog2(FFT_LEN);
  localparam int               HALF      = FFT_LEN / 2;
  localparam logic [CNT_W-1:0] LAST_BIN  = CNT_W'(FFT_LEN - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  fft_vis_pkg::fsm_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] emit_addr;
  logic              emit, done_set, err_set;
  logic [2:0]        err_pipe_q;

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q    <= fft_vis_pkg::IDLE;
      cnt_q      <= '0;
      err_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_pipe_q <= {err_pipe_q[1:0], err_set};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_addr = cnt_q[ADDR_W-1:0];
    done_set  = 1'b0;
    err_set   = 1'b0;
    if (i_fft_valid) begin
      if (i_fft_sop) begin
        // A sop always restarts at bin 0; sop+eop collapses into a single error.
        emit      = 1'b1;
        emit_addr = '0;
        err_set   = (state_q != fft_vis_pkg::IDLE) || i_fft_eop;
        cnt_d     = CNT_W'(1);
        state_d   = (HALF > 1) ? fft_vis_pkg::EMIT : fft_vis_pkg::DISCARD;
        if (i_fft_eop) begin
          cnt_d   = '0;
          state_d = fft_vis_pkg::IDLE;
        end
      end else begin
        case (state_q)
          fft_vis_pkg::EMIT: begin
            emit = 1'b1;
            if (i_fft_eop) begin
              err_set = 1'b1;
              cnt_d   = '0;
              state_d = fft_vis_pkg::IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
              if (cnt_q == HALF_LAST) state_d = fft_vis_pkg::DISCARD;
            end
          end
          fft_vis_pkg::DISCARD: begin
            if (i_fft_eop || cnt_q == LAST_BIN) begin
              done_set = i_fft_eop && (cnt_q == LAST_BIN);
              err_set  = !done_set;
              cnt_d    = '0;
              state_d  = fft_vis_pkg::IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  mag_approx_pipe #(
    .IN_W          (IN_W),
    .OUT_W         (OUT_W),
    .ADDR_W        (ADDR_W),
    .MAG_GAIN_SHIFT(MAG_GAIN_SHIFT)
  ) u_mag (
    .clk_i (sys_clk),
    .rst_i (sys_reset),
    .vld_i (emit),
    .tag_i (done_set),
    .re_i  (i_fft_real),
    .im_i  (i_fft_imag),
    .addr_i(emit_addr),
    .vld_o (o_fft_valid),
    .tag_o (o_frame_done),
    .addr_o(o_fft_addr),
    .mag_o (o_fft_mag)
  );

  assign o_frame_err = err_pipe_q[2];
endmodule

// File: tb/tb_fft_magnitude_stream.sv
// Bench for fft_magnitude_stream: random and directed frames checked against
// a sample-level framing/magnitude model with cycle-stamped expectations.
module tb_fft_magnitude_stream;
  localparam int FFT_LEN = 1024;
  localparam int HALF    = 512;
  localparam int SAT     = 16777215;

  logic        sys_clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic [15:0] i_fft_real = '0, i_fft_imag = '0;
  logic        i_fft_valid = 1'b0, i_fft_sop = 1'b0, i_fft_eop = 1'b0;
  logic [8:0]  o_fft_addr, s_addr;
  logic [23:0] o_fft_mag, s_mag;
  logic        o_fft_valid, o_frame_done, o_frame_err;
  logic        s_valid, s_done, s_err;

  fft_magnitude_stream dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .i_fft_real(i_fft_real), .i_fft_imag(i_fft_imag), .i_fft_valid(i_fft_valid),
    .i_fft_sop(i_fft_sop), .i_fft_eop(i_fft_eop),
    .o_fft_addr(o_fft_addr), .o_fft_mag(o_fft_mag), .o_fft_valid(o_fft_valid),
    .o_frame_done(o_frame_done), .o_frame_err(o_frame_err)
  );

  fft_magnitude_stream #(.MAG_GAIN_SHIFT(9)) dut_sat (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .i_fft_real(i_fft_real), .i_fft_imag(i_fft_imag), .i_fft_valid(i_fft_valid),
    .i_fft_sop(i_fft_sop), .i_fft_eop(i_fft_eop),
    .o_fft_addr(s_addr), .o_fft_mag(s_mag), .o_fft_valid(s_valid),
    .o_frame_done(s_done), .o_frame_err(s_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct {int addr; int mag; int mag_s; int t;} wr_t;
  wr_t exp_wr[$], act_wr[$], act_ws[$];
  int  exp_done[$], exp_err[$], act_done[$], act_err[$];
  bit  m_active = 0;
  int  m_idx = 0;

  always @(negedge sys_clk) begin
    if (o_fft_valid)  act_wr.push_back('{int'(o_fft_addr), int'(o_fft_mag), 0, cyc});
    if (s_valid)      act_ws.push_back('{int'(s_addr), int'(s_mag), 0, cyc});
    if (o_frame_done) act_done.push_back(cyc);
    if (o_frame_err)  act_err.push_back(cyc);
  end

  function automatic int ref_mag(int re, int im, int shift);
    int ar = (re < 0) ? -re : re;
    int ai = (im < 0) ? -im : im;
    int mx = (ar > ai) ? ar : ai;
    int mn = (ar > ai) ? ai : ar;
    longint m = longint'(mx + mn / 4 + mn / 8) * (longint'(1) << shift);
    return (m > SAT) ? SAT : int'(m);
  endfunction

  // Frame rules applied per accepted sample; t is the cycle the result should appear.
  function automatic void model(int re, int im, bit v, bit sop, bit eop, int t);
    if (!v) return;
    if (sop) begin
      if (m_active || eop) exp_err.push_back(t);
      exp_wr.push_back('{0, ref_mag(re, im, 4), ref_mag(re, im, 9), t});
      m_active = !eop;
      m_idx    = 1;
    end else if (m_active) begin
      if (m_idx < HALF) exp_wr.push_back('{m_idx, ref_mag(re, im, 4), ref_mag(re, im, 9), t});
      if (eop || m_idx == FFT_LEN - 1) begin
        if (eop && m_idx == FFT_LEN - 1) exp_done.push_back(t);
        else exp_err.push_back(t);
        m_active = 0;
      end else m_idx++;
    end
  endfunction

  function automatic void prune(int tmax);
    wr_t w[$];
    int  d[$], e[$];
    foreach (exp_wr[i])   if (exp_wr[i].t <= tmax) w.push_back(exp_wr[i]);
    foreach (exp_done[i]) if (exp_done[i] <= tmax) d.push_back(exp_done[i]);
    foreach (exp_err[i])  if (exp_err[i] <= tmax)  e.push_back(exp_err[i]);
    exp_wr = w; exp_done = d; exp_err = e;
  endfunction

  function automatic void clear_q();
    exp_wr.delete(); act_wr.delete(); act_ws.delete();
    exp_done.delete(); exp_err.delete(); act_done.delete(); act_err.delete();
  endfunction

  task automatic drive(input int re, input int im, input bit v, input bit sop, input bit eop);
    @(negedge sys_clk);
    i_fft_real  = re[15:0];
    i_fft_imag  = im[15:0];
    i_fft_valid = v;
    i_fft_sop   = sop;
    i_fft_eop   = eop;
    model(re, im, v, sop, eop, cyc + 3);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive($signed(16'($urandom)), $signed(16'($urandom)), 0, 1'($urandom), 1'($urandom));
  endtask

  task automatic send_frame(input int n, input int eop_at, input bit rnd, input int re, input int im, input int gap_pct);
    int r, q;
    for (int k = 0; k < n; k++) begin
      if (k > 0 && gap_pct > 0 && $urandom_range(99) < gap_pct) idle(1);
      r = rnd ? $signed(16'($urandom)) : re;
      q = rnd ? $signed(16'($urandom)) : im;
      drive(r, q, 1, k == 0, k == eop_at);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      if (k == 3) sys_reset = 1'b0;
      checks++;
      if ({o_fft_valid, o_frame_done, o_frame_err, o_fft_addr, o_fft_mag} !== '0) begin
        errors++;
        $display("FAIL reset_out[%0d] got v=%b d=%b e=%b a=%0d m=%0d want all 0", k, o_fft_valid, o_frame_done, o_frame_err, o_fft_addr, o_fft_mag);
      end
      checks++;
      if ({s_valid, s_done, s_err, s_addr, s_mag} !== '0) begin
        errors++;
        $display("FAIL reset_sat[%0d] got v=%b a=%0d m=%0d want all 0", k, s_valid, s_addr, s_mag);
      end
    end
  endtask

  task automatic test_clean_frame();
    bit ok;
    clear_q();
    send_frame(FFT_LEN, FFT_LEN - 1, 0, 3000, 4000, 0);
    idle(6);
    checks++;
    if (act_wr.size() != HALF) begin errors++; $display("FAIL clean_nwr got %0d want %0d", act_wr.size(), HALF); end
    foreach (act_wr[i]) begin
      checks++;
      if (act_wr[i].addr != i || act_wr[i].mag != 82000 || (i < exp_wr.size() && act_wr[i].t != exp_wr[i].t)) begin
        errors++;
        $display("FAIL clean_wr[%0d] got a=%0d m=%0d t=%0d want a=%0d m=82000", i, act_wr[i].addr, act_wr[i].mag, act_wr[i].t, i);
      end
    end
    ok = act_done.size() == exp_done.size();
    foreach (exp_done[i]) if (ok && act_done[i] != exp_done[i]) ok = 0;
    checks++;
    if (!ok || act_done.size() != 1) begin errors++; $display("FAIL clean_done got %0d pulses want 1 at t=%0d", act_done.size(), exp_done.size() ? exp_done[0] : -1); end
    checks++;
    if (act_err.size() != 0) begin errors++; $display("FAIL clean_err got %0d pulses want 0", act_err.size()); end
  endtask

  task automatic test_special_values();
    int r, q;
    clear_q();
    drive(-32768, 0, 1, 1, 0);
    drive(0, -5, 1, 0, 0);
    drive(-32768, -32768, 1, 0, 0);
    for (int k = 3; k < FFT_LEN; k++) begin
      r = $signed(16'($urandom)); q = $signed(16'($urandom));
      drive(r, q, 1, 0, k == FFT_LEN - 1);
    end
    idle(6);
    checks++;
    if (act_wr.size() < 3 || act_wr[0].mag != 524288 || act_wr[1].mag != 80 || act_wr[2].mag != 720896) begin
      errors++; $display("FAIL special_mag got %0d writes, want mags 524288,80,720896 first", act_wr.size());
    end
    checks++;
    if (act_ws.size() < 3 || act_ws[2].mag != SAT || act_ws[0].mag != SAT) begin
      errors++; $display("FAIL sat_mag got %0d writes, want mag[0]=mag[2]=%0d", act_ws.size(), SAT);
    end
    checks++;
    if (act_ws.size() != exp_wr.size()) begin errors++; $display("FAIL sat_nwr got %0d want %0d", act_ws.size(), exp_wr.size()); end
    for (int i = 0; i < act_ws.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (act_ws[i].addr != exp_wr[i].addr || act_ws[i].mag != exp_wr[i].mag_s || act_ws[i].t != exp_wr[i].t) begin
        errors++;
        $display("FAIL sat_wr[%0d] got a=%0d m=%0d t=%0d want a=%0d m=%0d t=%0d", i, act_ws[i].addr, act_ws[i].mag, act_ws[i].t, exp_wr[i].addr, exp_wr[i].mag_s, exp_wr[i].t);
      end
    end
    checks++;
    if (act_done.size() != 1 || act_err.size() != 0) begin errors++; $display("FAIL special_flags got done=%0d err=%0d want 1/0", act_done.size(), act_err.size()); end
  endtask

  task automatic test_sop_error();
    bit ok;
    clear_q();
    send_frame(300, -1, 1, 0, 0, 0);
    send_frame(FFT_LEN, FFT_LEN - 1, 1, 0, 0, 0);
    idle(6);
    checks++;
    if (act_wr.size() != exp_wr.size()) begin errors++; $display("FAIL soperr_nwr got %0d want %0d", act_wr.size(), exp_wr.size()); end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (act_wr[i].addr != exp_wr[i].addr || act_wr[i].mag != exp_wr[i].mag || act_wr[i].t != exp_wr[i].t) begin
        errors++;
        $display("FAIL soperr_wr[%0d] got a=%0d m=%0d t=%0d want a=%0d m=%0d t=%0d", i, act_wr[i].addr, act_wr[i].mag, act_wr[i].t, exp_wr[i].addr, exp_wr[i].mag, exp_wr[i].t);
      end
    end
    ok = (act_err.size() == 1) && (exp_err.size() == 1) && (act_err[0] == exp_err[0]);
    checks++;
    if (!ok) begin errors++; $display("FAIL soperr_err got %0d pulses want 1 at t=%0d", act_err.size(), exp_err.size() ? exp_err[0] : -1); end
    ok = (act_done.size() == 1) && (exp_done.size() == 1) && (act_done[0] == exp_done[0]);
    checks++;
    if (!ok) begin errors++; $display("FAIL soperr_done got %0d pulses want 1", act_done.size()); end
  endtask

  task automatic test_eop_and_missing();
    bit ok;
    clear_q();
    send_frame(701, 700, 1, 0, 0, 0);
    for (int k = 0; k < 40; k++) drive($signed(16'($urandom)), $signed(16'($urandom)), 1, 0, 1'($urandom));
    send_frame(FFT_LEN, -1, 1, 0, 0, 0);
    send_frame(10, 5, 1, 0, 0, 0);
    drive(1234, -4321, 1, 1, 1);
    for (int k = 0; k < 20; k++) drive($signed(16'($urandom)), $signed(16'($urandom)), 1, 0, 0);
    idle(6);
    checks++;
    if (act_wr.size() != exp_wr.size()) begin errors++; $display("FAIL eoperr_nwr got %0d want %0d", act_wr.size(), exp_wr.size()); end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (act_wr[i].addr != exp_wr[i].addr || act_wr[i].mag != exp_wr[i].mag || act_wr[i].t != exp_wr[i].t) begin
        errors++;
        $display("FAIL eoperr_wr[%0d] got a=%0d m=%0d t=%0d want a=%0d m=%0d t=%0d", i, act_wr[i].addr, act_wr[i].mag, act_wr[i].t, exp_wr[i].addr, exp_wr[i].mag, exp_wr[i].t);
      end
    end
    ok = act_err.size() == exp_err.size();
    foreach (exp_err[i]) if (ok && act_err[i] != exp_err[i]) ok = 0;
    checks++;
    if (!ok || act_err.size() != 4) begin errors++; $display("FAIL eoperr_err got %0d pulses want 4 at model times", act_err.size()); end
    checks++;
    if (act_done.size() != 0) begin errors++; $display("FAIL eoperr_done got %0d pulses want 0", act_done.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_q();
    send_frame(100, -1, 1, 0, 0, 0);
    @(negedge sys_clk);
    sys_reset = 1'b1; i_fft_valid = 1'b0;
    prune(cyc);
    m_active = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge sys_clk);
      if (k == 2) sys_reset = 1'b0;
      checks++;
      if ({o_fft_valid, o_frame_done, o_frame_err, o_fft_addr, o_fft_mag} !== '0) begin
        errors++;
        $display("FAIL rstmid_out[%0d] got v=%b d=%b e=%b a=%0d m=%0d want all 0", k, o_fft_valid, o_frame_done, o_frame_err, o_fft_addr, o_fft_mag);
      end
    end
    send_frame(FFT_LEN, FFT_LEN - 1, 1, 0, 0, 0);
    idle(6);
    checks++;
    if (act_wr.size() != exp_wr.size()) begin errors++; $display("FAIL rstmid_nwr got %0d want %0d", act_wr.size(), exp_wr.size()); end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (act_wr[i].addr != exp_wr[i].addr || act_wr[i].mag != exp_wr[i].mag || act_wr[i].t != exp_wr[i].t) begin
        errors++;
        $display("FAIL rstmid_wr[%0d] got a=%0d m=%0d t=%0d want a=%0d m=%0d t=%0d", i, act_wr[i].addr, act_wr[i].mag, act_wr[i].t, exp_wr[i].addr, exp_wr[i].mag, exp_wr[i].t);
      end
    end
    ok = (act_done.size() == 1) && (exp_done.size() == 1) && (act_done[0] == exp_done[0]);
    checks++;
    if (!ok || act_err.size() != 0) begin errors++; $display("FAIL rstmid_flags got done=%0d err=%0d want 1/0", act_done.size(), act_err.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_q();
    for (int f = 0; f < 3; f++) send_frame(FFT_LEN, FFT_LEN - 1, 1, 0, 0, 15);
    idle(6);
    checks++;
    if (act_wr.size() != exp_wr.size()) begin errors++; $display("FAIL b2b_nwr got %0d want %0d", act_wr.size(), exp_wr.size()); end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (act_wr[i].addr != exp_wr[i].addr || act_wr[i].mag != exp_wr[i].mag || act_wr[i].t != exp_wr[i].t) begin
        errors++;
        $display("FAIL b2b_wr[%0d] got a=%0d m=%0d t=%0d want a=%0d m=%0d t=%0d", i, act_wr[i].addr, act_wr[i].mag, act_wr[i].t, exp_wr[i].addr, exp_wr[i].mag, exp_wr[i].t);
      end
    end
    ok = act_done.size() == exp_done.size();
    foreach (exp_done[i]) if (ok && act_done[i] != exp_done[i]) ok = 0;
    checks++;
    if (!ok || act_done.size() != 3) begin errors++; $display("FAIL b2b_done got %0d pulses want 3 at model times", act_done.size()); end
    checks++;
    if (act_err.size() != 0) begin errors++; $display("FAIL b2b_err got %0d pulses want 0", act_err.size()); end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_special_values();
    test_sop_error();
    test_eop_and_missing();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no completion want finish before 2ms");
    $fatal(1, "timeout");
  end
endmodule
